// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - round-robin arbiter sharing one AXI AW+W slave port; define AXI_WARB_WLAST_GEN_EN to regenerate s_wlast from the beat count
module axi_write_arbiter #(
    parameter int NUM_M    = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WSTRB_W  = DATA_W / 8,
    parameter int AWLEN_W  = 8,
    parameter int AWSIZE_W = 3,
    parameter int ID_W     = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_M-1:0]            m_awvalid,
    output logic [NUM_M-1:0]            m_awready,
    input  logic [NUM_M*ADDR_W-1:0]     m_awaddr,
    input  logic [NUM_M*AWLEN_W-1:0]    m_awlen,
    input  logic [NUM_M*AWSIZE_W-1:0]   m_awsize,
    input  logic [NUM_M-1:0]            m_wvalid,
    output logic [NUM_M-1:0]            m_wready,
    input  logic [NUM_M*DATA_W-1:0]     m_wdata,
    input  logic [NUM_M*WSTRB_W-1:0]    m_wstrb,
    input  logic [NUM_M-1:0]            m_wlast,
    output logic                        s_awvalid,
    input  logic                        s_awready,
    output logic [ADDR_W-1:0]           s_awaddr,
    output logic [AWLEN_W-1:0]          s_awlen,
    output logic [AWSIZE_W-1:0]         s_awsize,
    output logic                        s_wvalid,
    input  logic                        s_wready,
    output logic [DATA_W-1:0]           s_wdata,
    output logic [WSTRB_W-1:0]          s_wstrb,
    output logic                        s_wlast,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy,
    output logic                        wlast_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     pick;
    logic                pick_vld;
    logic [AWLEN_W-1:0]  beat_cnt;
    logic                aw_hs;
    logic                w_hs;
    logic                last_beat;
    int                  g_idx;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = (int'(base) + 1 + k) % NUM_M;
        return ID_W'(s);
    endfunction

    // Search starts just after the previous owner so every requester is reached within NUM_M grants.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!pick_vld && m_awvalid[rr_idx(rr_ptr, k)]) begin
                pick_vld = 1'b1;
                pick     = rr_idx(rr_ptr, k);
            end
        end
    end

    assign g_idx     = int'(grant_id);
    assign aw_hs     = (state == S_AW) && s_awready;
    assign w_hs      = (state == S_W) && m_wvalid[grant_id] && s_wready;
    assign last_beat = (beat_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_AW;
            S_AW:    if (aw_hs) state_nxt = S_W;
            S_W:     if (w_hs && last_beat) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= ID_W'(NUM_M - 1);
            grant_id  <= '0;
            beat_cnt  <= '0;
            wlast_err <= 1'b0;
        end else begin
            if (state == S_IDLE && pick_vld) begin
                grant_id <= pick;
            end
            if (aw_hs) begin
                beat_cnt <= m_awlen[g_idx*AWLEN_W +: AWLEN_W];
            end else if (w_hs && !last_beat) begin
                beat_cnt <= beat_cnt - AWLEN_W'(1);
            end
            if (w_hs && last_beat) begin
                rr_ptr <= grant_id;
            end
            wlast_err <= w_hs && (m_wlast[grant_id] != last_beat);
        end
    end

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awsize  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_AW: begin
                s_awvalid           = 1'b1;
                s_awaddr            = m_awaddr[g_idx*ADDR_W +: ADDR_W];
                s_awlen             = m_awlen[g_idx*AWLEN_W +: AWLEN_W];
                s_awsize            = m_awsize[g_idx*AWSIZE_W +: AWSIZE_W];
                m_awready[grant_id] = s_awready;
            end
            S_W: begin
                s_wvalid           = m_wvalid[grant_id];
                s_wdata            = m_wdata[g_idx*DATA_W +: DATA_W];
                s_wstrb            = m_wstrb[g_idx*WSTRB_W +: WSTRB_W];
                m_wready[grant_id] = s_wready;
`ifdef AXI_WARB_WLAST_GEN_EN
                s_wlast            = last_beat;
`else
                s_wlast            = m_wlast[grant_id];
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb/tb_axi_write_arbiter.sv - directed and randomized self-checking bench for axi_write_arbiter (honours AXI_WARB_WLAST_GEN_EN)
module tb_axi_write_arbiter;

    localparam int NUM_M    = 3;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WSTRB_W  = DATA_W / 8;
    localparam int AWLEN_W  = 8;
    localparam int AWSIZE_W = 3;
    localparam int ID_W     = 2;
    localparam int NB       = 6;
`ifdef AXI_WARB_WLAST_GEN_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_M-1:0]           m_awvalid;
    logic [NUM_M-1:0]           m_awready;
    logic [NUM_M*ADDR_W-1:0]    m_awaddr;
    logic [NUM_M*AWLEN_W-1:0]   m_awlen;
    logic [NUM_M*AWSIZE_W-1:0]  m_awsize;
    logic [NUM_M-1:0]           m_wvalid;
    logic [NUM_M-1:0]           m_wready;
    logic [NUM_M*DATA_W-1:0]    m_wdata;
    logic [NUM_M*WSTRB_W-1:0]   m_wstrb;
    logic [NUM_M-1:0]           m_wlast;
    logic                       s_awvalid;
    logic                       s_awready;
    logic [ADDR_W-1:0]          s_awaddr;
    logic [AWLEN_W-1:0]         s_awlen;
    logic [AWSIZE_W-1:0]        s_awsize;
    logic                       s_wvalid;
    logic                       s_wready;
    logic [DATA_W-1:0]          s_wdata;
    logic [WSTRB_W-1:0]         s_wstrb;
    logic                       s_wlast;
    logic [ID_W-1:0]            grant_id;
    logic                       busy;
    logic                       wlast_err;

    int tests = 0;
    int fails = 0;

    axi_write_arbiter #(
        .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WSTRB_W(WSTRB_W),
        .AWLEN_W(AWLEN_W), .AWSIZE_W(AWSIZE_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .grant_id(grant_id), .busy(busy), .wlast_err(wlast_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_aw(input int i, input logic v, input logic [31:0] a, input logic [7:0] l);
        m_awvalid[i]                       = v;
        m_awaddr[i*ADDR_W +: ADDR_W]       = a;
        m_awlen[i*AWLEN_W +: AWLEN_W]      = l;
        m_awsize[i*AWSIZE_W +: AWSIZE_W]   = 3'd2;
    endtask

    task automatic set_w(input int i, input logic v, input logic [31:0] d, input logic l);
        m_wvalid[i]                        = v;
        m_wdata[i*DATA_W +: DATA_W]        = d;
        m_wstrb[i*WSTRB_W +: WSTRB_W]      = '1;
        m_wlast[i]                         = l;
    endtask

    // Returns on a falling edge with rst already released; the caller drives the first step there.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        m_awvalid = '0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_wvalid  = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = '0;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Random-phase reference state: burst tables and per-master progress.
    logic [31:0] r_addr [NUM_M][NB];
    logic [7:0]  r_len  [NUM_M][NB];
    logic [31:0] r_data [NUM_M][NB][8];
    int          aw_ptr [NUM_M];
    int          w_burst[NUM_M];
    int          w_beat [NUM_M];
    logic [32:0] expq[$];
    logic [32:0] ev;
    int          last_gnt;
    int          e;
    bit          done;

    function automatic int rr_next(input int last);
        for (int k = 1; k <= NUM_M; k++) begin
            if (aw_ptr[(last + k) % NUM_M] < NB) return (last + k) % NUM_M;
        end
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        do_reset();
        #1;
        chk("reset_outs", 64'({busy, s_awvalid, s_wvalid, m_awready, m_wready, wlast_err}), 64'h0);
        chk("reset_grant", 64'(grant_id), 64'h0);

        // single master 0, three beats
        set_aw(0, 1'b1, 32'h1000, 8'd2);
        #1;
        chk("t1_bubble", 64'(s_awvalid), 64'h0);
        @(negedge clk); #1;
        chk("t1_awvalid", 64'(s_awvalid), 64'h1);
        chk("t1_awaddr", 64'(s_awaddr), 64'h1000);
        chk("t1_awlen", 64'(s_awlen), 64'h2);
        chk("t1_awsize", 64'(s_awsize), 64'h2);
        chk("t1_grant", 64'(grant_id), 64'h0);
        chk("t1_awready", 64'(m_awready), 64'h1);
        @(negedge clk);
        set_aw(0, 1'b0, 32'h0, 8'd0);
        set_w(0, 1'b1, 32'hA000_0000, 1'b0);
        #1;
        chk("t1_wvalid", 64'(s_wvalid), 64'h1);
        chk("t1_wdata0", 64'(s_wdata), 64'hA000_0000);
        chk("t1_wstrb", 64'(s_wstrb), 64'hF);
        chk("t1_wready", 64'(m_wready), 64'h1);
        @(negedge clk);
        set_w(0, 1'b1, 32'hA000_0001, 1'b0);
        #1;
        chk("t1_wdata1", 64'(s_wdata), 64'hA000_0001);
        @(negedge clk);
        set_w(0, 1'b1, 32'hA000_0002, 1'b1);
        #1;
        chk("t1_wdata2", 64'(s_wdata), 64'hA000_0002);
        chk("t1_wlast", 64'(s_wlast), 64'h1);
        chk("t1_busy_last", 64'(busy), 64'h1);
        @(negedge clk);
        set_w(0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t1_busy_end", 64'(busy), 64'h0);
        chk("t1_wlast_err", 64'(wlast_err), 64'h0);

        // simultaneous requests: 0, then 1, then 0 again
        do_reset();
        set_aw(0, 1'b1, 32'h100, 8'd0);
        set_aw(1, 1'b1, 32'h200, 8'd0);
        @(negedge clk); #1;
        chk("t2_grant_a", 64'(grant_id), 64'h0);
        chk("t2_awready_a", 64'(m_awready), 64'h1);
        chk("t2_awaddr_a", 64'(s_awaddr), 64'h100);
        @(negedge clk);
        set_aw(0, 1'b0, 32'h0, 8'd0);
        set_w(0, 1'b1, 32'hA0, 1'b1);
        #1;
        chk("t2_wvalid_a", 64'(s_wvalid), 64'h1);
        @(negedge clk);
        set_w(0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t2_idle_a", 64'(busy), 64'h0);
        @(negedge clk); #1;
        chk("t2_grant_b", 64'(grant_id), 64'h1);
        chk("t2_awready_b", 64'(m_awready), 64'h2);
        chk("t2_awaddr_b", 64'(s_awaddr), 64'h200);
        @(negedge clk);
        set_aw(1, 1'b1, 32'h300, 8'd0);
        set_aw(0, 1'b1, 32'h400, 8'd0);
        set_w(1, 1'b1, 32'hB0, 1'b1);
        #1;
        chk("t2_wdata_b", 64'(s_wdata), 64'hB0);
        @(negedge clk);
        set_w(1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t2_idle_b", 64'(busy), 64'h0);
        @(negedge clk); #1;
        chk("t2_grant_c", 64'(grant_id), 64'h0);
        chk("t2_awready_c", 64'(m_awready), 64'h1);
        chk("t2_awaddr_c", 64'(s_awaddr), 64'h400);

        // W presented before AW grant must stall
        do_reset();
        s_awready = 1'b0;
        set_aw(1, 1'b1, 32'h500, 8'd0);
        set_w(1, 1'b1, 32'hBBBB_0001, 1'b1);
        #1;
        chk("t3_idle_wready", 64'(m_wready), 64'h0);
        chk("t3_idle_wvalid", 64'(s_wvalid), 64'h0);
        @(negedge clk); #1;
        chk("t3_aw_awvalid", 64'(s_awvalid), 64'h1);
        chk("t3_aw_wready", 64'(m_wready), 64'h0);
        chk("t3_aw_wvalid", 64'(s_wvalid), 64'h0);
        @(negedge clk);
        s_awready = 1'b1;
        #1;
        chk("t3_awready", 64'(m_awready), 64'h2);
        chk("t3_hs_wready", 64'(m_wready), 64'h0);
        @(negedge clk);
        set_aw(1, 1'b0, 32'h0, 8'd0);
        #1;
        chk("t3_w_wvalid", 64'(s_wvalid), 64'h1);
        chk("t3_w_wdata", 64'(s_wdata), 64'hBBBB_0001);
        chk("t3_w_wready", 64'(m_wready), 64'h2);
        @(negedge clk);
        set_w(1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t3_busy_end", 64'(busy), 64'h0);

        // early WLAST from the master
        do_reset();
        set_aw(0, 1'b1, 32'h600, 8'd2);
        @(negedge clk);
        @(negedge clk);
        set_aw(0, 1'b0, 32'h0, 8'd0);
        set_w(0, 1'b1, 32'hC0, 1'b0);
        #1;
        chk("t4_wlast_b0", 64'(s_wlast), 64'h0);
        @(negedge clk);
        set_w(0, 1'b1, 32'hC1, 1'b1);
        #1;
        chk("t4_wlast_b1", 64'(s_wlast), GEN ? 64'h0 : 64'h1);
        chk("t4_err_b1", 64'(wlast_err), 64'h0);
        @(negedge clk);
        set_w(0, 1'b1, 32'hC2, 1'b1);
        #1;
        chk("t4_err_pulse", 64'(wlast_err), 64'h1);
        chk("t4_wlast_b2", 64'(s_wlast), 64'h1);
        chk("t4_busy_b2", 64'(busy), 64'h1);
        @(negedge clk);
        set_w(0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t4_err_once", 64'(wlast_err), 64'h0);
        chk("t4_busy_end", 64'(busy), 64'h0);

        // s_wready stall for three cycles
        do_reset();
        set_aw(0, 1'b1, 32'h700, 8'd1);
        @(negedge clk);
        @(negedge clk);
        set_aw(0, 1'b0, 32'h0, 8'd0);
        set_w(0, 1'b1, 32'hD0, 1'b0);
        s_wready = 1'b0;
        #1;
        chk("t5_stall_wready", 64'(m_wready), 64'h0);
        chk("t5_stall_wvalid", 64'(s_wvalid), 64'h1);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); #1;
            chk("t5_stall_hold", 64'({m_wready, s_wdata}), 64'(32'hD0));
        end
        @(negedge clk);
        s_wready = 1'b1;
        #1;
        chk("t5_release_wready", 64'(m_wready), 64'h1);
        chk("t5_release_wdata", 64'(s_wdata), 64'hD0);
        @(negedge clk);
        set_w(0, 1'b1, 32'hD1, 1'b1);
        #1;
        chk("t5_b1_wdata", 64'(s_wdata), 64'hD1);
        chk("t5_b1_busy", 64'(busy), 64'h1);
        @(negedge clk);
        set_w(0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t5_busy_end", 64'(busy), 64'h0);

        // reset in the middle of a burst
        do_reset();
        set_aw(0, 1'b1, 32'h800, 8'd3);
        @(negedge clk);
        @(negedge clk);
        set_aw(0, 1'b0, 32'h0, 8'd0);
        set_w(0, 1'b1, 32'hE0, 1'b0);
        @(negedge clk);
        set_w(0, 1'b1, 32'hE1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_w(0, 1'b0, 32'h0, 1'b0);
        set_aw(1, 1'b1, 32'h2000, 8'd0);
        #1;
        chk("t6_reset_outs", 64'({busy, s_awvalid, s_wvalid, m_awready, m_wready, wlast_err, grant_id}), 64'h0);
        @(negedge clk); #1;
        chk("t6_grant", 64'(grant_id), 64'h1);
        chk("t6_awvalid", 64'(s_awvalid), 64'h1);
        chk("t6_awaddr", 64'(s_awaddr), 64'h2000);
        @(negedge clk);
        set_aw(1, 1'b0, 32'h0, 8'd0);
        set_w(1, 1'b1, 32'hF0, 1'b1);
        #1;
        chk("t6_wdata", 64'(s_wdata), 64'hF0);
        @(negedge clk);
        set_w(1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t6_busy_end", 64'(busy), 64'h0);

        // randomized traffic against a burst-level scoreboard
        for (int i = 0; i < NUM_M; i++) begin
            aw_ptr[i]  = 0;
            w_burst[i] = 0;
            w_beat[i]  = 0;
            for (int b = 0; b < NB; b++) begin
                r_addr[i][b] = $urandom;
                r_len[i][b]  = 8'($urandom_range(5));
                for (int j = 0; j < 8; j++) r_data[i][b][j] = $urandom;
            end
        end
        expq.delete();
        last_gnt = NUM_M - 1;
        done     = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            if (cyc != 0) @(negedge clk);
            for (int i = 0; i < NUM_M; i++) begin
                if (aw_ptr[i] < NB) set_aw(i, 1'b1, r_addr[i][aw_ptr[i]], r_len[i][aw_ptr[i]]);
                else                set_aw(i, 1'b0, 32'h0, 8'd0);
                if (w_burst[i] < NB)
                    set_w(i, $urandom_range(3) != 0, r_data[i][w_burst[i]][w_beat[i]],
                          w_beat[i] == int'(r_len[i][w_burst[i]]));
                else
                    set_w(i, 1'b0, 32'h0, 1'b0);
            end
            s_awready = 1'($urandom_range(1));
            s_wready  = ($urandom_range(3) != 0);
            #1;
            chk("rand_wlast_err", 64'(wlast_err), 64'h0);
            if (s_awvalid && s_awready) begin
                e = rr_next(last_gnt);
                if (e < 0) begin
                    chk("rand_aw_none_pending", 64'(s_awvalid), 64'h0);
                end else begin
                    chk("rand_grant", 64'(grant_id), 64'(e));
                    chk("rand_awaddr", 64'(s_awaddr), 64'(r_addr[e][aw_ptr[e]]));
                    chk("rand_awlen", 64'(s_awlen), 64'(r_len[e][aw_ptr[e]]));
                    for (int b = 0; b <= int'(r_len[e][aw_ptr[e]]); b++)
                        expq.push_back({b == int'(r_len[e][aw_ptr[e]]), r_data[e][aw_ptr[e]][b]});
                    last_gnt = e;
                end
                for (int i = 0; i < NUM_M; i++)
                    if (m_awvalid[i] && m_awready[i]) aw_ptr[i]++;
            end
            if (s_wvalid && s_wready) begin
                if (expq.size() == 0) begin
                    chk("rand_w_unexpected", 64'(s_wvalid), 64'h0);
                end else begin
                    ev = expq.pop_front();
                    chk("rand_wdata", 64'(s_wdata), 64'(ev[31:0]));
                    chk("rand_wlast", 64'(s_wlast), 64'(ev[32]));
                end
                for (int i = 0; i < NUM_M; i++) begin
                    if (m_wvalid[i] && m_wready[i]) begin
                        w_beat[i]++;
                        if (w_beat[i] > int'(r_len[i][w_burst[i]])) begin
                            w_burst[i]++;
                            w_beat[i] = 0;
                        end
                    end
                end
            end
            done = (expq.size() == 0);
            for (int i = 0; i < NUM_M; i++)
                if (aw_ptr[i] < NB || w_burst[i] < NB) done = 1'b0;
        end
        chk("rand_complete", 64'(done), 64'h1);
        @(negedge clk); #1;
        chk("rand_final_busy", 64'(busy), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
- Shares one AXI write slave port (AW + W channels) between NUM_M write masters.
- Round-robin arbitration on AW requests.
- Locks the W channel to the granted master until its burst completes (AWLEN+1 beats); one outstanding burst at a time.
- Sits between the master write ports and the downstream slave; the write protocol checker observes the slave-side bus.

Parameters:
NUM_M, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
WSTRB_W, DATA_W/8, strobe width
AWLEN_W, 8, burst length field width (beats-1)
AWSIZE_W, 3, burst size field width
ID_W, $clog2(NUM_M) (min 1), grant index width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
m_awvalid  in  NUM_M  per-master AW valid
m_awready  out  NUM_M  per-master AW ready
m_awaddr  in  NUM_M*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W]
m_awlen  in  NUM_M*AWLEN_W  packed
m_awsize  in  NUM_M*AWSIZE_W  packed
m_wvalid  in  NUM_M  per-master W valid
m_wready  out  NUM_M  per-master W ready
m_wdata  in  NUM_M*DATA_W  packed
m_wstrb  in  NUM_M*WSTRB_W  packed
m_wlast  in  NUM_M  per-master WLAST
s_awvalid/s_awready/s_awaddr/s_awlen/s_awsize  out/in/out/out/out  1/1/ADDR_W/AWLEN_W/AWSIZE_W  slave AW channel
s_wvalid/s_wready/s_wdata/s_wstrb/s_wlast  out/in/out/out/out  1/1/DATA_W/WSTRB_W/1  slave W channel
grant_id  out  ID_W  index of current owner, valid while busy=1
busy  out  1  high in AW and W states
wlast_err  out  1  one-cycle pulse: master WLAST disagrees with beat count

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset (incl. mid-burst): state=IDLE, rr_ptr=NUM_M-1 (master 0 highest priority first), beat_cnt=0. All outputs 0: s_awvalid, s_wvalid, m_awready, m_wready, busy, wlast_err, grant_id. Partial bursts are abandoned, not completed.
- FSM IDLE -> AW -> W -> IDLE.
- IDLE:
  - If any m_awvalid=1, pick the first set bit searching (rr_ptr+1) mod NUM_M upward, wrapping.
  - Register it into grant_id and go to AW.
  - Arbitration costs one bubble cycle: AW appears on s_aw* the cycle after the request is seen.
  - No request: stay IDLE.
- AW:
  - s_awvalid=1; s_awaddr/len/size are muxed combinationally from m_aw*[grant_id].
  - m_awready[grant_id]=s_awready; every other m_awready=0.
  - On s_awvalid&s_awready: latch beat_cnt=s_awlen, go to W.
  - The granted master must hold m_awvalid; the arbiter does not check this.
- W:
  - s_wvalid=m_wvalid[g]; s_wdata/wstrb muxed from g; m_wready[g]=s_wready; all other m_wready=0.
  - On each W handshake: if beat_cnt!=0, decrement; if beat_cnt==0, go to IDLE and set rr_ptr=g.
- W data is never accepted outside the W state, so W-before-AW stalls: m_wready=0 in IDLE and AW.
- wlast_err: registered, pulses the cycle after a W handshake where m_wlast[g] != (beat_cnt==0).
- awlen=0 is a single beat. awlen=2^AWLEN_W-1 is the max burst; beat_cnt is AWLEN_W bits, no overflow.
- Requests arriving while busy wait; the current burst is never preempted.
- Simultaneous final W handshake and a new m_awvalid: new arbitration happens in IDLE on the next cycle, using the updated rr_ptr.
- Paths from m_* to s_* are combinational; grant_id, state, beat_cnt and rr_ptr are registered.

Optional Feature:
AXI_WARB_WLAST_GEN_EN
- Defined: s_wlast = (state==W && beat_cnt==0); m_wlast is ignored for the downstream bus. Downstream always sees a correct WLAST; wlast_err still reports master mismatches.
- Undefined: s_wlast = m_wlast[grant_id] passed through. Burst termination still follows beat_cnt.

Test Plan:
- Single master 0, awaddr=0x1000, awlen=2, wready=1 -> s_awvalid 1 cycle after m_awvalid; 3 W beats forwarded; grant_id=0; busy drops after beat 3; wlast_err=0.
- Both masters request in the same cycle after reset -> master 0 is granted first (awlen=0); master 1 is granted next; then both again -> master 0 (alternation).
- Master 1 asserts m_wvalid before its AW grant -> m_wready[1]=0 until state W; no s_wvalid leak; data 0xBBBB0001 arrives after the AW handshake.
- Granted master asserts m_wlast on beat 2 of 3 (awlen=2) -> wlast_err pulses once; burst still ends after beat 3. With AXI_WARB_WLAST_GEN_EN: s_wlast=1 only on beat 3.
- s_wready held 0 for 3 cycles mid-burst, then 1 -> beat_cnt unchanged during stall; m_wready[g]=0; the beat completes on the first ready cycle.
- rst=1 mid-burst (after beat 1 of awlen=3) -> next cycle all outputs 0, state IDLE; a new request from master 1 is granted normally.
